booth_mac_seq: RTL
==================

# booth_mac_seq

Parametrised iterative radix-4 Booth multiply-accumulate unit, the next generation of the fixed 8-bit Booth multiplier in the user project area. It accepts WIDTH-bit signed or unsigned operand pairs over a valid/ready handshake and retires two multiplier bits per cycle. It can optionally accumulate products into a wide accumulator with sticky overflow. It sits behind the logic-analyzer and wishbone glue in the user project wrapper, clocked from the wishbone clock.

## Interface
- WIDTH, 8: operand width; even, 4..32.
- ACC_W, 2*WIDTH+8: accumulator/result width; must be ≥ 2*WIDTH.
- CLK  input  1  rising-edge clock, the only clock in the block.
- RST_N  input  1  reset, synchronous and active-low.
- IN_VALID  input  1  operand pair valid.
- IN_READY  output  1  block can accept operands.
- MX  input  WIDTH  multiplicand.
- MY  input  WIDTH  multiplier.
- SIGNED  input  1  1 = two's-complement operands, 0 = unsigned; sampled at accept.
- ACC_CLR  input  1  1 = load accumulator with this product, 0 = add; sampled at accept.
- OUT_VALID  output  1  RESULT valid.
- OUT_READY  input  1  consumer takes RESULT.
- RESULT  output  ACC_W  accumulator value, or the product alone.
- OVF  output  1  sticky accumulator overflow.

## Operation
- FSM states: IDLE, BUSY, DONE.
- IDLE:
  - IN_READY=1.
  - On IN_VALID&IN_READY, latch MX, MY, SIGNED and ACC_CLR.
  - Extend both operands to WIDTH+2 bits: sign-extend if SIGNED, zero-extend otherwise.
  - Clear the partial product, load iteration counter N=WIDTH/2+1, go to BUSY.
- BUSY:
  - Each cycle, recode the 3-bit Booth window {y[2i+1],y[2i],y[2i-1]} (y[-1]=0) into 0, ±M or ±2M.
  - Add the recoded term shifted by 2i into the (2*WIDTH+2)-bit partial product.
  - After N cycles go to DONE.
  - The exact product is the low 2*WIDTH bits, sign- or zero-extended to ACC_W per SIGNED.
- Entering DONE:
  - If ACC_CLR: accumulator = ext(product); OVF cleared.
  - Otherwise: accumulator = accumulator + ext(product), modulo 2^ACC_W.
  - OVF set (sticky) on signed overflow when SIGNED, on carry-out when unsigned.
- DONE:
  - OUT_VALID=1; RESULT=accumulator, held stable.
  - On OUT_READY go to IDLE.
  - OUT_VALID&OUT_READY in DONE and IN_VALID in the same cycle: no bypass; the new pair is accepted in the following IDLE cycle.
- Boundary cases:
  - Most-negative operands (-2^(WIDTH-1) × -2^(WIDTH-1)) produce the exact positive product; the 2-bit extension guarantees no recoding overflow.
  - MX or MY zero takes the same N cycles; there is no early termination.
  - Inputs other than IN_VALID are ignored outside an accept cycle.
- Reset (RST_N=0 at a rising edge), including mid-operation:
  - Aborts the operation and returns to IDLE.
  - Clears accumulator, partial product and OVF.

## Timing
- Reset values: IN_READY=1, OUT_VALID=0, RESULT=0, OVF=0.
- Accept edge = cycle 0. OUT_VALID rises after edge N+1 = WIDTH/2+2; WIDTH=8 → 6 cycles.
- Minimum initiation interval: N+3 cycles (accept, N busy, DONE, IDLE).
- All outputs are registered; no combinational path from any input to any output.
- IN_READY is low from the accept edge until the cycle after the OUT_VALID&OUT_READY handshake.

## Configuration
- BOOTH_MAC_ACC_EN defined:
  - Accumulator adder, ACC_CLR and OVF logic compiled in, as described above.
- Not defined:
  - Accumulator logic removed; ACC_CLR is ignored.
  - RESULT = ext(product) of the most recent operation only.
  - OVF is tied 0.
  - Latency and handshake are unchanged.

## Test plan
- WIDTH=8, SIGNED=1, ACC_CLR=1, MX=0x80, MY=0x80 → RESULT=0x4000, OVF=0, OUT_VALID 6 cycles after accept.
- SIGNED=0, ACC_CLR=1, MX=0xFF, MY=0xFF → RESULT=0xFE01; SIGNED=1 with the same operands → RESULT=1.
- Accumulate: 3×4 with ACC_CLR=1, then 5×6 with ACC_CLR=0, then (−2)×7 signed with ACC_CLR=0 → RESULTs 12, 42, 28.
- ACC_W=16, unsigned 0xFF×0xFF with CLR, then again without CLR → RESULT=0xFC02, OVF=1; next op with ACC_CLR=1 → OVF=0.
- Hold OUT_READY=0 for 10 cycles in DONE → RESULT stable, IN_READY=0, IN_VALID pulses ignored; release → one handshake, IN_READY=1 next cycle.
- RST_N=0 for one edge in cycle 3 of BUSY → OUT_VALID=0, RESULT=0, OVF=0, IN_READY=1; next operation 2×3 with ACC_CLR=0 → RESULT=6.

Source files
------------

// File: rtl/booth_mac_seq.sv
// Iterative radix-4 Booth multiply-accumulate unit that retires two multiplier bits per cycle.
// Define BOOTH_MAC_ACC_EN to compile in the accumulator, ACC_CLR handling and sticky OVF.
module booth_mac_seq #(
  parameter int WIDTH = 8,
  parameter int ACC_W = 2*WIDTH+8
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_in_valid,
  output logic             o_in_ready,
  input  logic [WIDTH-1:0] i_mx,
  input  logic [WIDTH-1:0] i_my,
  input  logic             i_signed,
  input  logic             i_acc_clr,
  output logic             o_out_valid,
  input  logic             i_out_ready,
  output logic [ACC_W-1:0] o_result,
  output logic             o_ovf
);

  localparam int PW    = 2*WIDTH+2;
  localparam int MW    = WIDTH+3;
  localparam int PRODW = 2*WIDTH;
  localparam int NITER = WIDTH/2+1;
  localparam int CW    = $clog2(NITER+1);

  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_t;

  state_t             r_state;
  logic               r_inReady;
  logic               r_outValid;
  logic [PW-1:0]      r_mcand;
  logic [MW-1:0]      r_mplier;
  logic [PW-1:0]      r_pp;
  logic [CW-1:0]      r_cnt;
  logic               r_signed;
  logic [ACC_W-1:0]   r_result;

  logic [PW-1:0]      w_mxExt;
  logic [MW-1:0]      w_myExt;
  logic [PW-1:0]      w_term;
  logic [PW-1:0]      w_ppNext;
  logic signed [PRODW-1:0] w_prodS;
  logic [ACC_W-1:0]   w_prodExt;

  // Multiplier carries an implicit y[-1]=0 at bit 0 so the Booth window is always r_mplier[2:0].
  assign w_mxExt = {{(PW-WIDTH){i_signed & i_mx[WIDTH-1]}}, i_mx};
  assign w_myExt = {{2{i_signed & i_my[WIDTH-1]}}, i_my, 1'b0};

  always_comb begin
    w_term = '0;
    case (r_mplier[2:0])
      3'b001, 3'b010: w_term = r_mcand;
      3'b011:         w_term = r_mcand << 1;
      3'b100:         w_term = -(r_mcand << 1);
      3'b101, 3'b110: w_term = -r_mcand;
      default:        w_term = '0;
    endcase
  end

  assign w_ppNext = r_pp + w_term;
  assign w_prodS  = r_pp[PRODW-1:0];

  always_comb begin
    w_prodExt = ACC_W'(r_pp[PRODW-1:0]);
    if (r_signed) begin
      w_prodExt = ACC_W'(w_prodS);
    end
  end

`ifdef BOOTH_MAC_ACC_EN
  logic             r_accClr;
  logic             r_ovf;
  logic [ACC_W:0]   w_accSum;
  logic             w_ovfNow;

  assign w_accSum = {1'b0, r_result} + {1'b0, w_prodExt};
  // Signed overflow: both addends share a sign that the sum does not; unsigned: carry-out.
  assign w_ovfNow = r_signed ?
                    ((r_result[ACC_W-1] == w_prodExt[ACC_W-1]) &&
                     (w_accSum[ACC_W-1] != r_result[ACC_W-1])) :
                    w_accSum[ACC_W];
  assign o_ovf = r_ovf;
`else
  logic w_unusedAccClr;
  assign w_unusedAccClr = i_acc_clr;
  assign o_ovf = 1'b0;
`endif

  // BUSY spends NITER cycles adding terms and one more folding the product into the result.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_state    <= S_IDLE;
      r_inReady  <= 1'b1;
      r_outValid <= 1'b0;
      r_mcand    <= '0;
      r_mplier   <= '0;
      r_pp       <= '0;
      r_cnt      <= '0;
      r_signed   <= 1'b0;
      r_result   <= '0;
`ifdef BOOTH_MAC_ACC_EN
      r_accClr   <= 1'b0;
      r_ovf      <= 1'b0;
`endif
    end else begin
      case (r_state)
        S_IDLE: begin
          if (i_in_valid) begin
            r_mcand   <= w_mxExt;
            r_mplier  <= w_myExt;
            r_signed  <= i_signed;
`ifdef BOOTH_MAC_ACC_EN
            r_accClr  <= i_acc_clr;
`endif
            r_pp      <= '0;
            r_cnt     <= CW'(NITER);
            r_inReady <= 1'b0;
            r_state   <= S_BUSY;
          end
        end
        S_BUSY: begin
          if (r_cnt != '0) begin
            r_pp     <= w_ppNext;
            r_mcand  <= r_mcand << 2;
            r_mplier <= r_mplier >> 2;
            r_cnt    <= r_cnt - 1'b1;
          end else begin
`ifdef BOOTH_MAC_ACC_EN
            if (r_accClr) begin
              r_result <= w_prodExt;
              r_ovf    <= 1'b0;
            end else begin
              r_result <= w_accSum[ACC_W-1:0];
              if (w_ovfNow) begin
                r_ovf <= 1'b1;
              end
            end
`else
            r_result <= w_prodExt;
`endif
            r_outValid <= 1'b1;
            r_state    <= S_DONE;
          end
        end
        S_DONE: begin
          if (i_out_ready) begin
            r_outValid <= 1'b0;
            r_inReady  <= 1'b1;
            r_state    <= S_IDLE;
          end
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign o_in_ready  = r_inReady;
  assign o_out_valid = r_outValid;
  assign o_result    = r_result;

endmodule
